// File: rtl/adder_share_arbiter.sv
// Round-robin time-multiplexer for one shared external combinational adder.
// Optional signed-overflow flag enabled by defining ADDER_ARB_OVF_EN.
module adder_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_in1,
  output logic [WIDTH-1:0]      add_in2,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_ovf
);

  typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   add_in1_q, add_in1_d;
  logic [WIDTH-1:0]   add_in2_q, add_in2_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               add_cin_q, add_cin_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [IDW-1:0]     gnt_idx;
  logic               gnt_found;
  logic [NREQ-1:0]    gnt_onehot;
  logic [31:0]        ptr_ext;
  int unsigned        idx;

  assign ptr_ext = 32'(rr_ptr_q);

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    gnt_idx    = '0;
    gnt_found  = 1'b0;
    gnt_onehot = '0;
    idx        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (ptr_ext + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
    if (gnt_found) gnt_onehot[gnt_idx] = 1'b1;
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  assign req_ready = (state_q == StIdle && rst_n) ? gnt_onehot : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    rsp_id_d    = rsp_id_q;
    add_in1_d   = add_in1_q;
    add_in2_d   = add_in2_q;
    add_cin_d   = add_cin_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          add_in1_d = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
          add_in2_d = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
          add_cin_d = req_cin[gnt_idx];
          gnt_id_d  = gnt_idx;
          state_d   = StAdd;
        end
      end
      StAdd: begin
        rsp_data_d  = add_result;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      rsp_id_q    <= '0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      add_cin_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      rsp_id_q    <= rsp_id_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      add_cin_q   <= add_cin_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  always_comb begin
    rsp_ovf_d = rsp_ovf_q;
    if (state_q == StAdd) begin
      rsp_ovf_d = (add_in1_q[WIDTH-1] == add_in2_q[WIDTH-1]) &
                  (add_result[WIDTH-1] != add_in1_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_ovf_q <= 1'b0;
    else        rsp_ovf_q <= rsp_ovf_d;
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter with a scoreboard of expected responses.
module tb_adder_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
`ifdef ADDER_ARB_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             ovf;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [WIDTH-1:0]      add_in1;
  logic [WIDTH-1:0]      add_in2;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ovf;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ptr = 0;

  always #5 clk = ~clk;

  // The shared external adder.
  assign add_result = add_in1 + add_in2 + {{(WIDTH-1){1'b0}}, add_cin};

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_cin    (add_cin),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf)
  );

  // Called at a negedge with the DUT idle; returns one negedge after the transfer edge.
  task automatic send(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic [WIDTH-1:0] exp_data, input logic exp_ovf);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_cin[id]              = cin;
    req_valid                = '0;
    req_valid[id]            = 1'b1;
    sb.push_back('{id: IDW'(id), data: exp_data, ovf: exp_ovf});
    @(negedge clk);
    req_valid = '0;
  endtask

  // Counts negedges since the drive negedge until rsp_valid, bounded.
  task automatic wait_rsp(output int n, output bit timeout);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    timeout = !rsp_valid;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_ovf, add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b id=%0d ovf=%b cin=%b required all 0",
               req_ready, rsp_valid, rsp_id, rsp_ovf, add_cin);
    end
    checks++;
    if ({add_in1, add_in2, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got in1=%h in2=%h data=%h required 0", add_in1, add_in2,
               rsp_data);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Accept requester 2, then reset while in ADD.
    req_a[2*WIDTH +: WIDTH] = 32'h1;
    req_b[2*WIDTH +: WIDTH] = 32'h2;
    req_cin[2] = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL reset_grant2: got %b required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (add_in1 !== 32'h1 || add_in2 !== 32'h2) begin
      errors++;
      $display("FAIL reset_latch: got %h/%h required 1/2", add_in1, add_in2);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_ovf, add_cin, add_in1, add_in2, rsp_data} !== '0)
    begin
      errors++;
      $display("FAIL reset_midadd: got vld=%b rdy=%b in1=%h in2=%h data=%h required 0",
               rsp_valid, req_ready, add_in1, add_in2, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_noresp: got rsp_valid raised required never");
    end
    exp_ptr = 0;
  endtask

  task automatic test_single();
    int n;
    bit to;
    exp_t e;
    send(0, 32'h5, 32'h7, 1'b1, 32'hD, 1'b0);
    wait_rsp(n, to);
    checks++;
    if (to || n != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d (timeout=%b) required 2", n, to);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_data !== e.data || rsp_id !== e.id) begin
      errors++;
      $display("FAIL single_rsp: got data=%h id=%0d required data=%h id=%0d",
               rsp_data, rsp_id, e.data, e.id);
    end
    exp_ptr = (int'(e.id) + 1) % NREQ;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (add_in1 !== 32'h5 || add_in2 !== 32'h7 || add_cin !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got in1=%h in2=%h cin=%b vld=%b required 5 7 1 0",
               add_in1, add_in2, add_cin, rsp_valid);
    end
  endtask

  task automatic test_wrap();
    int n;
    bit to;
    exp_t e;
    send(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0);
    wait_rsp(n, to);
    e = sb.pop_front();
    checks++;
    if (to || rsp_data !== e.data || rsp_id !== e.id || rsp_ovf !== e.ovf) begin
      errors++;
      $display("FAIL wrap_rsp: got data=%h id=%0d ovf=%b to=%b required data=%h id=%0d ovf=%b",
               rsp_data, rsp_id, rsp_ovf, to, e.data, e.id, e.ovf);
    end
    exp_ptr = (int'(e.id) + 1) % NREQ;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int   nrsp;
    int   last;
    bit   multi;
    exp_t e;
    logic [WIDTH-1:0] sums [NREQ];
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 32'h100 * (i + 1);
      req_b[i*WIDTH +: WIDTH] = 32'(i);
      req_cin[i] = (i % 2 == 1);
      sums[i] = 32'h100 * (i + 1) + 32'(i) + 32'(i % 2);
    end
    req_valid = '1;
    nrsp = 0;
    last = 0;
    multi = 1'b0;
    for (int cyc = 0; cyc < 40 && nrsp < 5; cyc++) begin
      #1;
      if ($countones(req_ready) > 1) multi = 1'b1;
      if (req_ready != '0) begin
        checks++;
        if (req_ready !== NREQ'(1 << exp_ptr)) begin
          errors++;
          $display("FAIL rr_grant: got %b required bit %0d", req_ready, exp_ptr);
        end
        sb.push_back('{id: IDW'(exp_ptr), data: sums[exp_ptr], ovf: 1'b0});
      end
      if (rsp_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : '{id: '0, data: 'x, ovf: 'x};
        checks++;
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          errors++;
          $display("FAIL rr_rsp: got id=%0d data=%h required id=%0d data=%h",
                   rsp_id, rsp_data, e.id, e.data);
        end
        if (nrsp > 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL rr_spacing: got %0d cycles required 3", cyc - last);
          end
        end
        last = cyc;
        exp_ptr = (int'(e.id) + 1) % NREQ;
        nrsp++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (nrsp != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d responses required 5", nrsp);
    end
    checks++;
    if (multi) begin
      errors++;
      $display("FAIL rr_onehot: got multi-hot req_ready required at most one bit");
    end
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int n;
    bit to;
    bit bad;
    exp_t e;
    rsp_ready = 1'b0;
    send(3, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0);
    wait_rsp(n, to);
    e = sb.pop_front();
    checks++;
    if (to || rsp_data !== e.data || rsp_id !== e.id) begin
      errors++;
      $display("FAIL bp_rsp: got data=%h id=%0d to=%b required data=%h id=%0d",
               rsp_data, rsp_id, to, e.data, e.id);
    end
    req_valid = '1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!(rsp_valid === 1'b1 && rsp_data === 32'h30 && rsp_id === 2'd3 && req_ready === '0))
        bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got unstable response or grant during stall required held");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_next_grant: got %b required 0001", req_ready);
    end
    req_valid = '0;
    exp_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int n;
    bit to;
    exp_t e;
    send(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, OvfEn);
    wait_rsp(n, to);
    e = sb.pop_front();
    checks++;
    if (to || rsp_data !== e.data || rsp_ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf_pos: got data=%h ovf=%b to=%b required data=%h ovf=%b",
               rsp_data, rsp_ovf, to, e.data, e.ovf);
    end
    @(negedge clk);
    send(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, OvfEn);
    wait_rsp(n, to);
    e = sb.pop_front();
    checks++;
    if (to || rsp_data !== e.data || rsp_ovf !== e.ovf || rsp_id !== e.id) begin
      errors++;
      $display("FAIL ovf_neg: got data=%h ovf=%b id=%0d to=%b required data=%h ovf=%b id=%0d",
               rsp_data, rsp_ovf, rsp_id, to, e.data, e.ovf, e.id);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_back_pressure();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
